minterm_fn_unit: RTL
====================

# minterm_fn_unit

Parametrised, programmable minterm function unit: an N-to-2^N decoder with enable, plus a run-time loadable truth table that ORs selected minterms into one output `f`. It replaces the fixed 4-to-16 decode-and-OR function with a registered, handshaked block. The truth table is serially reloadable, and a sweep mode counts the true minterms. It sits between a select source, such as a controller or switch bank, and logic that consumes the one-hot decode and/or the function bit.

## Interface
- `N`, 4: select width; table width T = 2^N.
- `RESET_TABLE`, 16'hC2CA: T-bit truth table loaded at reset; bit k = value of f for minterm k; default = minterms {1,3,6,7,9,14,15}.

- `clk` input 1: the block's one clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: decode enable; when 0, the registered `y` and `f` evaluate to 0.
- `in_valid` input 1: select valid.
- `in_w` input N: minterm select.
- `in_ready` output 1: select accepted when `in_valid & in_ready`.
- `out_valid` output 1: one-cycle pulse marking new `y`/`f`.
- `y` output T: registered one-hot decode of accepted `in_w`.
- `f` output 1: registered `table[in_w]`.
- `cfg_valid` input 1: serial table bit valid.
- `cfg_bit` input 1: table bit, minterm 0 first.
- `cfg_ready` output 1: cfg bit accepted when `cfg_valid & cfg_ready`.
- `sweep_start` input 1: request a minterm count.
- `sweep_busy` output 1: sweep in progress.
- `sweep_done` output 1: one-cycle pulse at sweep end.
- `sweep_count` output N+1: number of 1 bits in the active table, range 0..T.

## Operation
- FSM states: IDLE, LOAD, SWEEP.
- Reset: state=IDLE; table=RESET_TABLE; shadow and bit counter cleared; `y`=0, `f`=0; `out_valid`=0, `sweep_busy`=0, `sweep_done`=0, `sweep_count`=0.
- `in_ready` = (state==IDLE) & ~cfg_valid & ~sweep_start.
- `cfg_ready` = state != SWEEP.
- Priority when several requests arrive in IDLE in the same cycle: `cfg_valid` > `sweep_start` > `in_valid`. Losers are not accepted and must be held by the source; `sweep_start` is sampled in IDLE only.
- Evaluate (IDLE): an accepted `in_w` registers `y` = en ? (1<<in_w) : 0 and `f` = en & table[in_w]; `out_valid` pulses. `y`/`f` hold between accepts. There is no output backpressure.
- LOAD: the first accepted cfg bit moves IDLE to LOAD. Each accepted bit shifts into the shadow: shadow = {cfg_bit, shadow[T-1:1]}. The counter counts 0..T-1.
  - The T-th accepted bit commits shadow to table in the same edge, then the FSM returns to IDLE.
  - The active table is unchanged until commit; a partial load never becomes visible.
  - Gaps in `cfg_valid` are allowed; there is no timeout.
- SWEEP: index steps 0..T-1, one per cycle, accumulating table[index] into an internal counter.
  - After index T-1: `sweep_count` is updated, `sweep_done` pulses, state returns to IDLE.
  - `sweep_count` holds until the next sweep completes. A table load does not clear it.
- Reset mid-LOAD discards the shadow and restores RESET_TABLE. Reset mid-SWEEP aborts it, with `sweep_count`=0.
- `en` does not affect LOAD or SWEEP.

## Timing
- Evaluate latency is 1: accept at edge k, so `y`/`f`/`out_valid` are valid after edge k. Throughput is 1 select per cycle.
- Load takes T accepted bits (minimum T cycles). The first select accepted after commit uses the new table.
- Sweep:
  - `sweep_busy` is high T cycles, starting the cycle after `sweep_start` is sampled.
  - `sweep_done` and the new `sweep_count` appear the cycle after the last busy cycle.
  - `in_ready` is 0 throughout.
- `in_ready` and `cfg_ready` are combinational from state and requests. All other outputs are registered.

## Structure
- Package `minterm_pkg`: the state enum (IDLE/LOAD/SWEEP) and the default-table constant C2CA.
- Sub-module `decoder_n` (parameter N; ports w, en, y): combinational one-hot decoder with enable, instantiated once for `y`. The function bit is taken by indexing the table, not by ORing decode bits.
- The counter widths follow from N (log2 T + 1).

## Test plan
- Reset, then `in_w`=9 with `en`=1 -> after one edge, `out_valid`=1, `y`=16'h0200, `f`=1. `in_w`=2 -> `f`=0, `y`=16'h0004.
- `en`=0, `in_w`=7 accepted -> `out_valid`=1, `y`=0, `f`=0.
- Load 16 bits for table 16'h0001 with random `cfg_valid` gaps:
  - during the load, `in_w`=0 is not accepted (`in_ready`=0);
  - after commit, `in_w`=0 -> `f`=1 and `in_w`=15 -> `f`=0.
- `sweep_start` on the reset table -> `sweep_busy` high 16 cycles, then `sweep_done` pulse with `sweep_count`=7. On table 16'hFFFF -> `sweep_count`=16 (full width).
- Assert `rst` after 10 of 16 cfg bits -> table reads back 16'hC2CA (`in_w`=1 -> `f`=1); the next full 16-bit load succeeds.
- `cfg_valid`, `sweep_start` and `in_valid` together in IDLE -> only the cfg bit is accepted, state=LOAD, no `out_valid`. `sweep_start` held through the load then starts its sweep.

Source files
------------

// File: rtl/minterm_fn_unit_pkg.sv
// Shared types and constants for the minterm function unit.
// Holds the controller state encoding and the default truth table.
package minterm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    // Minterms {1,3,6,7,9,14,15}
    localparam logic [15:0] DEFAULT_TABLE = 16'hC2CA;

endpackage

// File: rtl/minterm_fn_unit_decoder_n.sv
// N-to-2^N one-hot decoder with enable.
// Purely combinational; all-zero output when disabled.
module decoder_n #(
    parameter int N = 4
) (
    input  logic [N-1:0]        w,
    input  logic                en,
    output logic [(1<<N)-1:0]   y
);

    localparam int T = 1 << N;

    // One-hot select of w, gated by en
    always_comb begin
        y = '0;
        if (en) y = T'(1) << w;
    end

endmodule

// File: rtl/minterm_fn_unit.sv
// Programmable minterm function unit: registered decode plus
// serially loadable truth table and a true-minterm counter.
module minterm_fn_unit
    import minterm_pkg::*;
#(
    parameter int                N           = 4,
    parameter logic [(1<<N)-1:0] RESET_TABLE = DEFAULT_TABLE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_valid,
    input  logic [N-1:0]        in_w,
    output logic                in_ready,
    output logic                out_valid,
    output logic [(1<<N)-1:0]   y,
    output logic                f,
    input  logic                cfg_valid,
    input  logic                cfg_bit,
    output logic                cfg_ready,
    input  logic                sweep_start,
    output logic                sweep_busy,
    output logic                sweep_done,
    output logic [N:0]          sweep_count
);

    localparam int T = 1 << N;

    state_t         state;
    logic [T-1:0]   truth_table;
    logic [T-1:0]   shadow;
    logic [T-1:0]   shadow_next;
    logic [N-1:0]   bit_cnt;
    logic [N-1:0]   sweep_idx;
    logic [N:0]     sweep_acc;
    logic [N:0]     sweep_acc_next;
    logic [T-1:0]   dec_y;
    logic           last_bit;
    logic           last_idx;

    decoder_n #(.N(N)) u_dec (
        .w  (in_w),
        .en (en),
        .y  (dec_y)
    );

    // Config bits win over sweeps, sweeps win over selects
    assign in_ready  = (state == IDLE) & ~cfg_valid & ~sweep_start;
    assign cfg_ready = (state != SWEEP);

    // Bits arrive minterm 0 first, so shift in from the top
    assign shadow_next    = {cfg_bit, shadow[T-1:1]};
    assign last_bit       = (bit_cnt == N'(T-1));
    assign last_idx       = (sweep_idx == N'(T-1));
    assign sweep_acc_next = sweep_acc + (N+1)'(truth_table[sweep_idx]);

    // Controller, table storage and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            truth_table <= RESET_TABLE;
            shadow      <= '0;
            bit_cnt     <= '0;
            sweep_idx   <= '0;
            sweep_acc   <= '0;
            y           <= '0;
            f           <= 1'b0;
            out_valid   <= 1'b0;
            sweep_busy  <= 1'b0;
            sweep_done  <= 1'b0;
            sweep_count <= '0;
        end else begin
            out_valid  <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        shadow  <= shadow_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= LOAD;
                    end else if (sweep_start) begin
                        sweep_idx  <= '0;
                        sweep_acc  <= '0;
                        sweep_busy <= 1'b1;
                        state      <= SWEEP;
                    end else if (in_valid) begin
                        y         <= dec_y;
                        f         <= en & truth_table[in_w];
                        out_valid <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        shadow <= shadow_next;
                        if (last_bit) begin
                            truth_table <= shadow_next;
                            bit_cnt     <= '0;
                            state       <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    sweep_acc <= sweep_acc_next;
                    sweep_idx <= sweep_idx + 1'b1;
                    if (last_idx) begin
                        sweep_count <= sweep_acc_next;
                        sweep_done  <= 1'b1;
                        sweep_busy  <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
